// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
//   Shared types and helpers for the raster timing generator.
//   - timing_t    : blank / sync / jump / end points for one raster axis
//   - DRUAGA_H/V  : default Druaga/Namco axis timings (384 px x 263 lines)
//   - clamp_edge(): applies a signed 4-bit sync-position adjust to a nominal
//                   edge and clamps it into the visited part of the axis
// -----------------------------------------------------------------------------
package video_timing_pkg;

    localparam int VT_CW = 9;

    typedef struct packed {
        logic [VT_CW-1:0] blank_end;    // count at which blank deasserts
        logic [VT_CW-1:0] blank_start;  // count at which blank asserts
        logic [VT_CW-1:0] sync_start;   // nominal sync_n fall
        logic [VT_CW-1:0] sync_end;     // nominal sync_n rise
        logic [VT_CW-1:0] jump_from;    // count after which jump_to is loaded
        logic [VT_CW-1:0] jump_to;      // load value after jump_from
        logic [VT_CW-1:0] cnt_end;      // last count, wraps to zero
    } timing_t;

    localparam timing_t DRUAGA_H = '{
        blank_end:   9'd1,
        blank_start: 9'd290,
        sync_start:  9'd311,
        sync_end:    9'd342,
        jump_from:   9'd342,
        jump_to:     9'd471,
        cnt_end:     9'd511
    };

    // Vertical blank deasserts on the wrap, so blank_end equals cnt_end.
    localparam timing_t DRUAGA_V = '{
        blank_end:   9'd511,
        blank_start: 9'd223,
        sync_start:  9'd234,
        sync_end:    9'd241,
        jump_from:   9'd241,
        jump_to:     9'd491,
        cnt_end:     9'd511
    };

    // base + adj, evaluated one bit wider and signed so a negative adjust on a
    // small base cannot wrap around, then clamped into [lo, hi].  lo is one
    // past blank start and hi is the jump point, so the result is always a
    // count the axis actually visits.
    function automatic logic [VT_CW-1:0] clamp_edge(
        input logic [VT_CW-1:0]  base,
        input logic signed [3:0] adj,
        input logic [VT_CW-1:0]  lo,
        input logic [VT_CW-1:0]  hi
    );
        logic signed [VT_CW:0] sum;
        logic signed [VT_CW:0] lo_s;
        logic signed [VT_CW:0] hi_s;
        logic [VT_CW-1:0]      result;
        sum  = $signed({1'b0, base}) + $signed({{(VT_CW-3){adj[3]}}, adj});
        lo_s = $signed({1'b0, lo});
        hi_s = $signed({1'b0, hi});
        if (sum < lo_s) begin
            result = lo;
        end else if (sum > hi_s) begin
            result = hi;
        end else begin
            result = sum[VT_CW-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// -----------------------------------------------------------------------------
// video_axis_counter
//   One raster axis: position counter with jump and wrap, blank flag and
//   active-low sync, all advancing only when i_step is high.
//
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   i_step     in   advance enable (pixel enable for H, H wrap for V)
//   i_sync_on  in   count at which o_sync_n falls (already adjusted/clamped)
//   i_sync_off in   count at which o_sync_n rises (already adjusted/clamped)
//   o_cnt      out  current count
//   o_blank    out  blank flag, active high
//   o_sync_n   out  sync, active low
//   o_wrap     out  high with i_step when the count wraps cnt_end -> 0
// -----------------------------------------------------------------------------
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int      CW     = VT_CW,
    parameter timing_t TIMING = DRUAGA_H
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          i_step,
    input  logic [CW-1:0] i_sync_on,
    input  logic [CW-1:0] i_sync_off,
    output logic [CW-1:0] o_cnt,
    output logic          o_blank,
    output logic          o_sync_n,
    output logic          o_wrap
);

    localparam logic [CW-1:0] L_BLANK_END   = CW'(TIMING.blank_end);
    localparam logic [CW-1:0] L_BLANK_START = CW'(TIMING.blank_start);
    localparam logic [CW-1:0] L_JUMP_FROM   = CW'(TIMING.jump_from);
    localparam logic [CW-1:0] L_JUMP_TO     = CW'(TIMING.jump_to);
    localparam logic [CW-1:0] L_END         = CW'(TIMING.cnt_end);

    logic [CW-1:0] r_cnt;
    logic          r_blank;
    logic          r_sync_n;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_blank_nxt;
    logic          w_sync_n_nxt;

    // Next-state for count, blank and sync; the three compares are independent
    // so a sync edge on the jump count takes effect together with the jump.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_blank_nxt  = r_blank;
        w_sync_n_nxt = r_sync_n;
        if (i_step) begin
            if (r_cnt == L_BLANK_END) begin
                w_blank_nxt = 1'b0;
            end else if (r_cnt == L_BLANK_START) begin
                w_blank_nxt = 1'b1;
            end else begin
                w_blank_nxt = r_blank;
            end

            if (r_cnt == i_sync_on) begin
                w_sync_n_nxt = 1'b0;
            end else if (r_cnt == i_sync_off) begin
                w_sync_n_nxt = 1'b1;
            end else begin
                w_sync_n_nxt = r_sync_n;
            end

            if (r_cnt == L_JUMP_FROM) begin
                w_cnt_nxt = L_JUMP_TO;
            end else if (r_cnt == L_END) begin
                w_cnt_nxt = {CW{1'b0}};
            end else begin
                w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            w_cnt_nxt    = r_cnt;
            w_blank_nxt  = r_blank;
            w_sync_n_nxt = r_sync_n;
        end
    end

    // Axis state registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= {CW{1'b0}};
            r_blank  <= 1'b1;
            r_sync_n <= 1'b1;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_blank  <= w_blank_nxt;
            r_sync_n <= w_sync_n_nxt;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_blank  = r_blank;
    assign o_sync_n = r_sync_n;
    assign o_wrap   = i_step && (r_cnt == L_END);

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Parametrised raster timing generator.  Divides clk_sys down to a pixel
//   enable, runs the H and V axis counters, applies a per-frame sync position
//   adjust and gates/registers the core RGB.
//
//   clk_sys      in   system clock
//   reset_n      in   asynchronous active-low reset
//   h_adj        in   signed hsync shift, -8..+7 pixels (sampled at frame start)
//   v_adj        in   signed vsync shift, -8..+7 lines  (sampled at frame start)
//   rgb_in       in   core pixel
//   ce_pix       out  one-clk_sys pulse per pixel
//   hpos, vpos   out  current horizontal / vertical count
//   hblank       out  horizontal blank, active high
//   vblank       out  vertical blank, active high
//   hsync_n      out  horizontal sync, active low
//   vsync_n      out  vertical sync, active low
//   rgb_out      out  registered pixel, zero during any blank
//   line_start   out  pulse with ce_pix when hcnt wraps to 0
//   frame_start  out  pulse with ce_pix when vcnt wraps to 0
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CE_DIV        = 8,
    parameter int DW            = 12,
    parameter int CW            = VT_CW,
    parameter int H_BLANK_END   = 1,
    parameter int H_BLANK_START = 290,
    parameter int H_SYNC_START  = 311,
    parameter int H_SYNC_END    = 342,
    parameter int H_JUMP_FROM   = 342,
    parameter int H_JUMP_TO     = 471,
    parameter int H_END         = 511,
    parameter int V_BLANK_START = 223,
    parameter int V_SYNC_START  = 234,
    parameter int V_SYNC_END    = 241,
    parameter int V_JUMP_FROM   = 241,
    parameter int V_JUMP_TO     = 491,
    parameter int V_END         = 511
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic signed [3:0]   h_adj,
    input  logic signed [3:0]   v_adj,
    input  logic [DW-1:0]       rgb_in,
    output logic                ce_pix,
    output logic [CW-1:0]       hpos,
    output logic [CW-1:0]       vpos,
    output logic                hblank,
    output logic                vblank,
    output logic                hsync_n,
    output logic                vsync_n,
    output logic [DW-1:0]       rgb_out,
    output logic                line_start,
    output logic                frame_start
);

    localparam int               DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    localparam timing_t H_TIMING = '{
        blank_end:   VT_CW'(H_BLANK_END),
        blank_start: VT_CW'(H_BLANK_START),
        sync_start:  VT_CW'(H_SYNC_START),
        sync_end:    VT_CW'(H_SYNC_END),
        jump_from:   VT_CW'(H_JUMP_FROM),
        jump_to:     VT_CW'(H_JUMP_TO),
        cnt_end:     VT_CW'(H_END)
    };

    // Vertical blank ends on the frame wrap.
    localparam timing_t V_TIMING = '{
        blank_end:   VT_CW'(V_END),
        blank_start: VT_CW'(V_BLANK_START),
        sync_start:  VT_CW'(V_SYNC_START),
        sync_end:    VT_CW'(V_SYNC_END),
        jump_from:   VT_CW'(V_JUMP_FROM),
        jump_to:     VT_CW'(V_JUMP_TO),
        cnt_end:     VT_CW'(V_END)
    };

    logic [DIV_W-1:0]   r_div;
    logic signed [3:0]  r_h_adj_l;
    logic signed [3:0]  r_v_adj_l;
    logic [DW-1:0]      r_rgb;

    logic               w_ce;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_hblank;
    logic               w_vblank;
    logic [CW-1:0]      w_hs_on;
    logic [CW-1:0]      w_hs_off;
    logic [CW-1:0]      w_vs_on;
    logic [CW-1:0]      w_vs_off;

    // Pixel divider: free-running 0..CE_DIV-1, enable on the last count.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= {DIV_W{1'b0}};
        end else if (r_div == DIV_LAST) begin
            r_div <= {DIV_W{1'b0}};
        end else begin
            r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    assign w_ce = (r_div == DIV_LAST);

    // Adjust latches: only the frame-start pixel samples the inputs, so a
    // change mid-frame never moves a sync edge the counter has already passed.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_h_adj_l <= 4'sd0;
            r_v_adj_l <= 4'sd0;
        end else if (w_v_wrap) begin
            r_h_adj_l <= h_adj;
            r_v_adj_l <= v_adj;
        end else begin
            r_h_adj_l <= r_h_adj_l;
            r_v_adj_l <= r_v_adj_l;
        end
    end

    // Clamped sync edges; the window [blank_start+1, jump_from] is always
    // visited, so every programmed edge is reached within the frame.
    assign w_hs_on  = CW'(clamp_edge(VT_CW'(H_SYNC_START), r_h_adj_l,
                                     VT_CW'(H_BLANK_START + 1), VT_CW'(H_JUMP_FROM)));
    assign w_hs_off = CW'(clamp_edge(VT_CW'(H_SYNC_END), r_h_adj_l,
                                     VT_CW'(H_BLANK_START + 1), VT_CW'(H_JUMP_FROM)));
    assign w_vs_on  = CW'(clamp_edge(VT_CW'(V_SYNC_START), r_v_adj_l,
                                     VT_CW'(V_BLANK_START + 1), VT_CW'(V_JUMP_FROM)));
    assign w_vs_off = CW'(clamp_edge(VT_CW'(V_SYNC_END), r_v_adj_l,
                                     VT_CW'(V_BLANK_START + 1), VT_CW'(V_JUMP_FROM)));

    video_axis_counter #(
        .CW     (CW),
        .TIMING (H_TIMING)
    ) u_h_axis (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_step     (w_ce),
        .i_sync_on  (w_hs_on),
        .i_sync_off (w_hs_off),
        .o_cnt      (hpos),
        .o_blank    (w_hblank),
        .o_sync_n   (hsync_n),
        .o_wrap     (w_h_wrap)
    );

    // The vertical axis advances once per line, on the H wrap pixel.
    video_axis_counter #(
        .CW     (CW),
        .TIMING (V_TIMING)
    ) u_v_axis (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_step     (w_h_wrap),
        .i_sync_on  (w_vs_on),
        .i_sync_off (w_vs_off),
        .o_cnt      (vpos),
        .o_blank    (w_vblank),
        .o_sync_n   (vsync_n),
        .o_wrap     (w_v_wrap)
    );

    // RGB gate: uses the blank flags as they stand before this pixel's
    // update, giving one pixel of latency relative to hpos.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= {DW{1'b0}};
        end else if (w_ce) begin
            r_rgb <= (w_hblank || w_vblank) ? {DW{1'b0}} : rgb_in;
        end else begin
            r_rgb <= r_rgb;
        end
    end

    assign ce_pix      = w_ce;
    assign hblank      = w_hblank;
    assign vblank      = w_vblank;
    assign rgb_out     = r_rgb;
    assign line_start  = w_h_wrap;
    assign frame_start = w_v_wrap;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//   Directed bench for video_timing_gen.  The default H timing is kept; the V
//   axis is shortened (lines 0..25, 510..511 = 28 lines) and CE_DIV is 2 so
//   several whole frames fit in a short run.  Outputs are sampled 1 time unit
//   after each rising edge, i.e. on a ce_pix sample the counters still show
//   the value the coming pixel edge acts on.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int CE_DIV        = 2;
    localparam int DW            = 12;
    localparam int CW            = 9;
    localparam int V_BLANK_START = 10;
    localparam int V_SYNC_START  = 18;
    localparam int V_SYNC_END    = 25;
    localparam int V_JUMP_FROM   = 25;
    localparam int V_JUMP_TO     = 510;
    localparam int V_END         = 511;
    localparam int PIX_PER_LINE  = 384;
    localparam int LINES         = 28;

    logic                clk_sys = 1'b0;
    logic                reset_n = 1'b0;
    logic signed [3:0]   h_adj   = 4'sd0;
    logic signed [3:0]   v_adj   = 4'sd0;
    logic [DW-1:0]       rgb_in  = 12'hFFF;
    logic                ce_pix;
    logic [CW-1:0]       hpos;
    logic [CW-1:0]       vpos;
    logic                hblank;
    logic                vblank;
    logic                hsync_n;
    logic                vsync_n;
    logic [DW-1:0]       rgb_out;
    logic                line_start;
    logic                frame_start;

    int      n_checks   = 0;
    int      n_fail     = 0;
    longint  cyc        = 0;
    bit      prev_blank = 1'b1;
    logic [DW-1:0] prev_rgb = 12'h000;
    int      rgb_err    = 0;
    int      rgb_bad    = -1;

    video_timing_gen #(
        .CE_DIV        (CE_DIV),
        .DW            (DW),
        .CW            (CW),
        .V_BLANK_START (V_BLANK_START),
        .V_SYNC_START  (V_SYNC_START),
        .V_SYNC_END    (V_SYNC_END),
        .V_JUMP_FROM   (V_JUMP_FROM),
        .V_JUMP_TO     (V_JUMP_TO),
        .V_END         (V_END)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .h_adj       (h_adj),
        .v_adj       (v_adj),
        .rgb_in      (rgb_in),
        .ce_pix      (ce_pix),
        .hpos        (hpos),
        .vpos        (vpos),
        .hblank      (hblank),
        .vblank      (vblank),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .rgb_out     (rgb_out),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 64'd1;

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic bail(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected DUT event not seen within bound", what);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    endtask

    // Advance to the next ce_pix sample; also runs the one-pixel-late RGB
    // gate model and drives the next pixel value.
    task automatic next_ce(output int waited);
        logic [DW-1:0] exp_rgb;
        waited = 0;
        do begin
            @(posedge clk_sys);
            #1;
            waited++;
        end while (!ce_pix && waited < 4 * CE_DIV);
        if (!ce_pix) bail("ce_pix");
        exp_rgb = prev_blank ? 12'h000 : prev_rgb;
        if (rgb_out !== exp_rgb) begin
            rgb_err++;
            if (rgb_bad < 0) rgb_bad = int'(hpos);
        end
        prev_blank = hblank | vblank;
        rgb_in     = hpos[0] ? 12'hFFF : 12'h5A3;
        prev_rgb   = rgb_in;
    endtask

    task automatic wait_line_start();
        int w;
        int n;
        n = 0;
        do begin
            next_ce(w);
            n++;
        end while (!line_start && n < 2 * PIX_PER_LINE);
        if (!line_start) bail("wait_line_start");
    endtask

    task automatic wait_frame_start();
        int w;
        int n;
        n = 0;
        do begin
            next_ce(w);
            n++;
        end while (!frame_start && n < 40 * PIX_PER_LINE);
        if (!frame_start) bail("wait_frame_start");
    endtask

    // From a line_start sample, step one full line of pixels and report the
    // hsync fall count, hsync/hblank low pixel counts and clk_sys cycles.
    task automatic walk_line(output int fall, output int hs_low, output int hb_low,
                             output int cycles);
        longint c0;
        int     w;
        int     prev_h;
        c0     = cyc;
        fall   = -1;
        hs_low = 0;
        hb_low = 0;
        prev_h = int'(hpos);
        for (int i = 0; i < PIX_PER_LINE; i++) begin
            next_ce(w);
            if (!hsync_n) begin
                hs_low++;
                if (fall < 0) fall = prev_h;
            end
            if (!hblank) hb_low++;
            prev_h = int'(hpos);
        end
        cycles = int'(cyc - c0);
    endtask

    // From a frame_start sample, walk lines until the next frame_start.
    // The adjust inputs are changed to mid_h/mid_v after the third line.
    task automatic run_frame(input logic signed [3:0] mid_h, input logic signed [3:0] mid_v,
                             output int lines, output int fall0, output int hs_low0,
                             output int fall_bad, output int vs_first, output int vs_low,
                             output int vb_low, output int cycles);
        longint c0;
        int     f;
        int     hl;
        int     hb;
        int     lc;
        c0       = cyc;
        lines    = 0;
        fall0    = -1;
        hs_low0  = -1;
        fall_bad = 0;
        vs_first = -1;
        vs_low   = 0;
        vb_low   = 0;
        do begin
            walk_line(f, hl, hb, lc);
            if (lines == 0) begin
                fall0   = f;
                hs_low0 = hl;
            end else if (f != fall0) begin
                fall_bad++;
            end
            lines++;
            if (lines == 3) begin
                h_adj = mid_h;
                v_adj = mid_v;
            end
            if (!line_start) bail("run_frame line_start");
            if (!vsync_n) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(vpos);
            end
            if (!vblank) vb_low++;
        end while (!frame_start && lines < 64);
        cycles = int'(cyc - c0);
    endtask

    task automatic test_reset();
        int w;
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        if ({hpos, vpos} !== 18'd0) begin
            n_fail++; $display("FAIL reset_pos: hpos=%0d vpos=%0d, required 0/0", hpos, vpos);
        end
        n_checks++;
        if ({hblank, vblank, hsync_n, vsync_n} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_flags: hb/vb/hs_n/vs_n=%b, required 1111",
                               {hblank, vblank, hsync_n, vsync_n});
        end
        n_checks++;
        if ({rgb_out, ce_pix, line_start, frame_start} !== 15'd0) begin
            n_fail++; $display("FAIL reset_out: rgb=%h ce=%b ls=%b fs=%b, required 0",
                               rgb_out, ce_pix, line_start, frame_start);
        end
        n_checks++;
        @(negedge clk_sys);
        reset_n = 1'b1;
        // ce_pix is seen high in the CE_DIV-th cycle after release.
        next_ce(w);
        if (w !== CE_DIV - 1) begin
            n_fail++; $display("FAIL first_ce: seen after %0d edges, required %0d", w, CE_DIV - 1);
        end
        n_checks++;
        if (hpos !== 9'd0) begin
            n_fail++; $display("FAIL first_ce_hpos: hpos=%0d, required 0", hpos);
        end
        n_checks++;
    endtask

    task automatic test_divider();
        int w;
        for (int i = 1; i <= 4; i++) begin
            next_ce(w);
            if (w !== CE_DIV) begin
                n_fail++; $display("FAIL ce_period: %0d cycles, required %0d", w, CE_DIV);
            end
            n_checks++;
            if (hpos !== 9'(i)) begin
                n_fail++; $display("FAIL hpos_step: hpos=%0d, required %0d", hpos, i);
            end
            n_checks++;
        end
    endtask

    task automatic test_line();
        int f;
        int hl;
        int hb;
        int lc;
        rgb_err = 0;
        rgb_bad = -1;
        wait_line_start();
        walk_line(f, hl, hb, lc);
        if (f !== 311) begin
            n_fail++; $display("FAIL hsync_fall: at %0d, required 311", f);
        end
        n_checks++;
        if (hl !== 31) begin
            n_fail++; $display("FAIL hsync_width: %0d pixels, required 31", hl);
        end
        n_checks++;
        if (hb !== 289) begin
            n_fail++; $display("FAIL hblank_low: %0d pixels, required 289", hb);
        end
        n_checks++;
        if (lc !== PIX_PER_LINE * CE_DIV) begin
            n_fail++; $display("FAIL line_period: %0d cycles, required %0d", lc, PIX_PER_LINE * CE_DIV);
        end
        n_checks++;
        if (hpos !== 9'd511) begin
            n_fail++; $display("FAIL line_start_pos: hpos=%0d, required 511", hpos);
        end
        n_checks++;
        if (rgb_err !== 0) begin
            n_fail++; $display("FAIL rgb_gate_line: %0d bad pixels, first at hpos %0d, required 0",
                               rgb_err, rgb_bad);
        end
        n_checks++;
    endtask

    task automatic check_frame(input string tag, input int lines, input int fall0, input int hs_low0,
                               input int fall_bad, input int vs_first, input int vs_low,
                               input int vb_low, input int cycles, input int exp_fall,
                               input int exp_vs_first, input int exp_vs_low);
        if (lines !== LINES) begin
            n_fail++; $display("FAIL %s_lines: %0d, required %0d", tag, lines, LINES);
        end
        n_checks++;
        if (cycles !== LINES * PIX_PER_LINE * CE_DIV) begin
            n_fail++; $display("FAIL %s_period: %0d cycles, required %0d", tag, cycles,
                               LINES * PIX_PER_LINE * CE_DIV);
        end
        n_checks++;
        if (fall0 !== exp_fall || hs_low0 !== 31) begin
            n_fail++; $display("FAIL %s_hsync: fall %0d width %0d, required %0d/31", tag, fall0,
                               hs_low0, exp_fall);
        end
        n_checks++;
        if (fall_bad !== 0) begin
            n_fail++; $display("FAIL %s_hsync_stable: %0d lines moved, required 0", tag, fall_bad);
        end
        n_checks++;
        if (vs_first !== exp_vs_first || vs_low !== exp_vs_low) begin
            n_fail++; $display("FAIL %s_vsync: first %0d lines %0d, required %0d/%0d", tag,
                               vs_first, vs_low, exp_vs_first, exp_vs_low);
        end
        n_checks++;
        if (vb_low !== 11) begin
            n_fail++; $display("FAIL %s_vblank: %0d active lines, required 11", tag, vb_low);
        end
        n_checks++;
        if (rgb_err !== 0) begin
            n_fail++; $display("FAIL %s_rgb_gate: %0d bad pixels, first at hpos %0d, required 0",
                               tag, rgb_err, rgb_bad);
        end
        n_checks++;
    endtask

    task automatic test_frame_default();
        int ln, f0, h0, fb, vf, vl, vb, cy;
        wait_frame_start();
        rgb_err = 0;
        rgb_bad = -1;
        // Adjust changes to -3/-8 mid-frame: must stay invisible this frame.
        run_frame(-4'sd3, -4'sd8, ln, f0, h0, fb, vf, vl, vb, cy);
        check_frame("frame_default", ln, f0, h0, fb, vf, vl, vb, cy, 311, 19, 7);
    endtask

    task automatic test_adjust_latch();
        int ln, f0, h0, fb, vf, vl, vb, cy;
        rgb_err = 0;
        rgb_bad = -1;
        // -3 latched: hsync 308..338; v_adj -8 clamps vsync on to line 11.
        run_frame(4'sd7, -4'sd8, ln, f0, h0, fb, vf, vl, vb, cy);
        check_frame("frame_adj", ln, f0, h0, fb, vf, vl, vb, cy, 308, 12, 6);
    endtask

    task automatic test_adjust_plus7();
        int f;
        int hl;
        int hb;
        int lc;
        walk_line(f, hl, hb, lc);
        if (f !== 318 || hl !== 24) begin
            n_fail++; $display("FAIL hadj_plus7: fall %0d width %0d, required 318/24", f, hl);
        end
        n_checks++;
        if (vpos !== 9'd0) begin
            n_fail++; $display("FAIL hadj_plus7_line: vpos=%0d, required 0", vpos);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        int w;
        int n;
        n = 0;
        do begin
            next_ce(w);
            n++;
        end while (hpos !== 9'd100 && n < 2 * PIX_PER_LINE);
        if (hpos !== 9'd100) bail("reach_hpos_100");
        #2;
        reset_n = 1'b0;
        #1;
        prev_blank = 1'b1;
        if ({hpos, vpos, hblank, vblank, hsync_n, vsync_n} !== {18'd0, 4'b1111}) begin
            n_fail++; $display("FAIL async_reset_state: h=%0d v=%0d flags=%b, required 0/0/1111",
                               hpos, vpos, {hblank, vblank, hsync_n, vsync_n});
        end
        n_checks++;
        if ({rgb_out, line_start, frame_start} !== 14'd0) begin
            n_fail++; $display("FAIL async_reset_out: rgb=%h ls=%b fs=%b, required 0",
                               rgb_out, line_start, frame_start);
        end
        n_checks++;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        next_ce(w);
        if (w !== CE_DIV - 1 || hpos !== 9'd0) begin
            n_fail++; $display("FAIL restart_first: edges %0d hpos %0d, required %0d/0",
                               w, hpos, CE_DIV - 1);
        end
        n_checks++;
        next_ce(w);
        if (hpos !== 9'd1 || vpos !== 9'd0) begin
            n_fail++; $display("FAIL restart_count: h=%0d v=%0d, required 1/0", hpos, vpos);
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_divider();
        test_line();
        test_frame_default();
        test_adjust_latch();
        test_adjust_plus7();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
